// File: rtl/fifo_read_streamer_if.sv
// fifo_read_streamer_if
//   Bundles the two handshakes the read streamer sits between: the read
//   side of a synchronous FIFO and the downstream valid/ready stream.
//   master : the streamer (drives fifo_r_en, m_valid, m_data)
//   slave  : the FIFO/sink environment (drives fifo_empty, fifo_dout, m_ready)
// Signals
//   fifo_empty  FIFO empty flag
//   fifo_r_en   FIFO read strobe
//   fifo_dout   FIFO read data, valid one cycle after fifo_r_en
//   m_valid     output word valid
//   m_data      output word
//   m_ready     downstream accepts m_data when m_valid & m_ready
interface fifo_read_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_r_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_r_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer
//   Read-side master for a synchronous FIFO. Issues reads whenever data is
//   available and there is room, absorbs the FIFO's one-cycle read latency
//   in a 2-entry output buffer and presents the words on a valid/ready
//   stream, counting every word accepted downstream.
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   en        1 = stream FIFO contents, 0 = stop issuing reads
//   bus       fifo_read_streamer_if.master (FIFO read side + output stream)
//   rd_count  words accepted downstream since reset (wraps)
//   busy      state not IDLE, a read outstanding, or buffer non-empty
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fifo_read_streamer_if.master bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [1:0]            r_bufCnt;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [CNT_WIDTH-1:0]  r_rdCount;
  logic                  w_run;
  logic                  w_pop;
  logic [2:0]            w_level;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. FLUSH waits only for the last issued read to return;
  // the buffer keeps draining in every state.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (en) w_nextState = RUN;
      RUN:     if (!en) w_nextState = FLUSH;
      FLUSH: begin
        if (en) begin
          w_nextState = RUN;
        end else if (!r_pend) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    w_run = (r_state == RUN);
    busy  = (r_state != IDLE) | r_pend | (r_bufCnt != 2'd0);
  end

  assign w_pop = bus.m_valid & bus.m_ready;

  // Occupancy the buffer will have once the outstanding read lands and this
  // cycle's pop leaves. Taking the pop into account makes m_ready reach
  // fifo_r_en combinationally, which is what sustains one word per clock.
  assign w_level = {1'b0, r_bufCnt} + {2'b00, r_pend} - {2'b00, w_pop};

  assign bus.fifo_r_en = ~rst & w_run & ~bus.fifo_empty & (w_level < 3'd2);
  assign bus.m_valid   = (r_bufCnt != 2'd0);
  assign bus.m_data    = r_buf0;
  assign rd_count      = r_rdCount;

  // Output buffer: r_buf0 is the head. A word returns the cycle after its
  // read (r_pend); clearing r_pend in reset discards whatever the FIFO
  // presents the cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= 1'b0;
      r_bufCnt <= 2'd0;
      r_buf0   <= '0;
      r_buf1   <= '0;
    end else begin
      r_pend <= bus.fifo_r_en;
      case ({r_pend, w_pop})
        2'b01: begin
          r_buf0   <= r_buf1;
          r_bufCnt <= r_bufCnt - 2'd1;
        end
        2'b10: begin
          if (r_bufCnt == 2'd0) begin
            r_buf0 <= bus.fifo_dout;
          end else begin
            r_buf1 <= bus.fifo_dout;
          end
          r_bufCnt <= r_bufCnt + 2'd1;
        end
        2'b11: begin
          if (r_bufCnt == 2'd1) begin
            r_buf0 <= bus.fifo_dout;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.fifo_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Delivered-word counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdCount <= '0;
    end else if (w_pop) begin
      r_rdCount <= r_rdCount + 1'b1;
    end
  end

  // The issue rule must keep a returning word from landing in a full buffer
  noOverflow: assert property (@(posedge clk) disable iff (rst)
    !(r_pend && !w_pop && (r_bufCnt == 2'd2)));

endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer
//   Self-checking bench for fifo_read_streamer. A behavioural synchronous
//   FIFO feeds the DUT; every word written into it is also pushed onto an
//   expected-word scoreboard, which a negedge monitor pops as beats are
//   accepted downstream. CNT_WIDTH is 4 so rd_count wrap is reachable.
module tb_fifo_read_streamer;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mReady;
  logic          fifoEmpty = 1'b1;
  logic [DW-1:0] fifoDout  = '0;
  logic [CW-1:0] rdCount;
  logic          busy;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] wrQ[$];
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] popWord;

  int vectorCount     = 0;
  int missCount       = 0;
  int readsIssued     = 0;
  int beatsAccepted   = 0;
  int beatsSinceReset = 0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData  = '0;

  fifo_read_streamer_if #(.DATA_WIDTH(DW)) bus ();

  assign bus.fifo_empty = fifoEmpty;
  assign bus.fifo_dout  = fifoDout;
  assign bus.m_ready    = mReady;

  fifo_read_streamer #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus),
    .rd_count(rdCount),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Writes one word into the FIFO model and records it as expected output
  task automatic applyStimulus(input logic [DW-1:0] word);
    wrQ.push_back(word);
    expQ.push_back(word);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input int maxCycles, input bit randReady);
    for (int i = 0; i < maxCycles && expQ.size() != 0; i++) begin
      if (randReady) mReady = 1'($urandom_range(0, 1));
      tick(1);
    end
    checkOutput("drainDone", expQ.size(), 0);
  endtask

  task automatic waitIdle(input int maxCycles);
    for (int i = 0; i < maxCycles && busy; i++) begin
      tick(1);
    end
    checkOutput("idleReached", busy, 0);
  endtask

  // Synchronous FIFO model: read data registered one cycle after r_en,
  // writes become visible (empty drops) after the clock edge
  always @(posedge clk) begin
    if (bus.fifo_r_en && fifoQ.size() > 0) begin
      popWord = fifoQ.pop_front();
      fifoDout <= popWord;
    end
    while (wrQ.size() > 0) fifoQ.push_back(wrQ.pop_front());
    fifoEmpty <= (fifoQ.size() == 0);
  end

  // Monitor: everything sampled mid-cycle, describing the coming edge
  always @(negedge clk) begin
    if (rst) begin
      beatsSinceReset = 0;
      prevStall = 1'b0;
    end else begin
      if (bus.fifo_r_en) begin
        readsIssued++;
        checkOutput("rEnWhileEmpty", fifoEmpty, 0);
      end
      if (prevStall) begin
        checkOutput("holdValid", bus.m_valid, 1);
        checkOutput("holdData", bus.m_data, prevData);
      end
      if (bus.m_valid && bus.m_ready) begin
        checkOutput("rdCountBeat", rdCount, beatsSinceReset % (1 << CW));
        checkOutput("scoreboardNonEmpty", expQ.size() > 0, 1);
        if (expQ.size() > 0) checkOutput("beatData", bus.m_data, expQ.pop_front());
        beatsAccepted++;
        beatsSinceReset++;
      end
      prevStall = bus.m_valid && !bus.m_ready;
      prevData  = bus.m_data;
    end
  end

  initial begin
    int readsBefore;
    int drop;
    int remaining;
    bit found;

    rst = 1'b1;
    en = 1'b0;
    mReady = 1'b0;
    tick(2);
    checkOutput("rstValid", bus.m_valid, 0);
    checkOutput("rstData", bus.m_data, 0);
    checkOutput("rstCount", rdCount, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstREn", bus.fifo_r_en, 0);
    rst = 1'b0;
    tick(1);

    $display("[TB] T1 three words");
    mReady = 1'b1;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    en = 1'b1;
    waitDrain(40, 1'b0);
    checkOutput("t1Count", rdCount, 3);
    en = 1'b0;
    waitIdle(10);

    $display("[TB] T2 eight back-to-back words");
    for (int i = 0; i < 8; i++) applyStimulus(8'h40 + 8'(i));
    tick(3);
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = bus.fifo_r_en;
    end
    checkOutput("t2Start", found, 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("t2REn", bus.fifo_r_en, (k < 8));
      checkOutput("t2Valid", bus.m_valid, (k >= 2));
    end
    tick(1);
    en = 1'b0;
    waitDrain(20, 1'b0);
    waitIdle(10);
    checkOutput("t2Count", rdCount, 11);

    $display("[TB] T3 backpressure");
    mReady = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'h50 + 8'(i));
    en = 1'b1;
    tick(10);
    checkOutput("t3Valid", bus.m_valid, 1);
    checkOutput("t3REn", bus.fifo_r_en, 0);
    checkOutput("t3FifoLeft", fifoQ.size(), 3);
    checkOutput("t3Head", bus.m_data, 8'h50);
    tick(3);
    checkOutput("t3HeadStable", bus.m_data, 8'h50);
    mReady = 1'b1;
    waitDrain(40, 1'b0);
    checkOutput("t3CountWrap", rdCount, 0);
    en = 1'b0;
    waitIdle(10);

    $display("[TB] T4 drop en with a read in flight");
    for (int i = 0; i < 4; i++) applyStimulus(8'h60 + 8'(i));
    tick(3);
    readsBefore = readsIssued;
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = bus.fifo_r_en;
    end
    checkOutput("t4Start", found, 1);
    en = 1'b0;
    tick(1);
    waitIdle(20);
    checkOutput("t4Reads", readsIssued - readsBefore, 1);
    checkOutput("t4FifoLeft", fifoQ.size(), 3);
    checkOutput("t4Count", rdCount, 1);
    checkOutput("t4ExpLeft", expQ.size(), 3);

    $display("[TB] T5 reset mid-stream");
    for (int i = 0; i < 5; i++) applyStimulus(8'h70 + 8'(i));
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.fifo_r_en && bus.m_valid;
    end
    checkOutput("t5Streaming", found, 1);
    tick(1);
    // Words read from the FIFO but not yet accepted are lost by the reset
    rst = 1'b1;
    en = 1'b0;
    drop = readsIssued - beatsAccepted;
    for (int i = 0; i < drop && expQ.size() > 0; i++) void'(expQ.pop_front());
    tick(1);
    rst = 1'b0;
    checkOutput("t5Valid", bus.m_valid, 0);
    checkOutput("t5Count", rdCount, 0);
    checkOutput("t5Busy", busy, 0);
    tick(2);
    checkOutput("t5Discard", bus.m_valid, 0);
    remaining = expQ.size();
    en = 1'b1;
    waitDrain(40, 1'b0);
    checkOutput("t5Remaining", rdCount, remaining % (1 << CW));
    en = 1'b0;
    waitIdle(10);

    $display("[TB] T6 counter wrap over 20 words");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(8'h80 + 8'(i));
    en = 1'b1;
    waitDrain(300, 1'b1);
    mReady = 1'b1;
    checkOutput("t6CountWrap", rdCount, 4);
    en = 1'b0;
    waitIdle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
